// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings and the byte-lane mask decode used by the SRAM bridge.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int LANES = 4;

  function automatic logic [3:0] byte_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (hsize)
      HSIZE_BYTE: m = 4'b0001 << addr_lo;
      HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer: holds a write deferred by a colliding read, requests its
// drain, and merges buffered lanes into SRAM read data when the read hits the buffer.
module ahb_sram_wbuf
  import ahb_sram_pkg::*;
#(
  parameter int WAW = 14
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic           drain_ack_i,
  input  logic [WAW-1:0] ld_addr_i,
  input  logic [3:0]     ld_mask_i,
  input  logic [31:0]    ld_data_i,
  input  logic           rd_ap_i,
  input  logic [WAW-1:0] dp_addr_i,
  input  logic [31:0]    sram_rdata_i,
  output logic           pend_o,
  output logic           drain_req_o,
  output logic [WAW-1:0] buf_addr_o,
  output logic [3:0]     buf_mask_o,
  output logic [31:0]    buf_data_o,
  output logic [31:0]    fwd_rdata_o
);

  logic           pend_q, pend_d;
  logic [WAW-1:0] addr_q, addr_d;
  logic [3:0]     mask_q, mask_d;
  logic [31:0]    data_q, data_d;
  logic           hit_s;

  // Buffer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      mask_q <= 4'b0000;
      data_q <= 32'h0000_0000;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
      mask_q <= mask_d;
      data_q <= data_d;
    end
  end

  // Load on a deferred write, clear pend once the drain has used the SRAM port
  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    mask_d = mask_q;
    data_d = data_q;
    if (load_i) begin
      pend_d = 1'b1;
      addr_d = ld_addr_i;
      mask_d = ld_mask_i;
      data_d = ld_data_i;
    end else if (drain_ack_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Lane-merge forwarding of buffered bytes over stale SRAM data
  always_comb begin
    hit_s       = pend_q && (addr_q == dp_addr_i);
    fwd_rdata_o = sram_rdata_i;
    for (int i = 0; i < LANES; i++) begin
      if (hit_s && mask_q[i]) begin
        fwd_rdata_o[8*i +: 8] = data_q[8*i +: 8];
      end else begin
        fwd_rdata_o[8*i +: 8] = sram_rdata_i[8*i +: 8];
      end
    end
  end

  assign pend_o      = pend_q;
  assign drain_req_o = pend_q & ~rd_ap_i;
  assign buf_addr_o  = addr_q;
  assign buf_mask_o  = mask_q;
  assign buf_data_o  = data_q;

endmodule

// File: rtl/ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite slave driving a single-port synchronous SRAM; reads own the
// port in their address phase, colliding writes are parked in ahb_sram_wbuf.
module ahb_sram_bridge
  import ahb_sram_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS
);

  localparam int WAW = AW - 2;

  logic           xfer_s, rd_ap_s, wr_ap_s;
  logic           dp_read_q, dp_read_d, dp_write_q, dp_write_d;
  logic [WAW-1:0] dp_addr_q, dp_addr_d;
  logic [3:0]     dp_mask_q, dp_mask_d;
  logic           defer_s, drain_req_s, drain_ack_s, buf_pend_s;
  logic [WAW-1:0] buf_addr_s;
  logic [3:0]     buf_mask_s;
  logic [31:0]    buf_data_s, fwd_rdata_s;
  logic           trans_unused_s;

  assign trans_unused_s = HTRANS[0];
  assign xfer_s  = HSEL & HREADY & HTRANS[1];
  assign rd_ap_s = xfer_s & ~HWRITE;
  assign wr_ap_s = xfer_s & HWRITE;

  // Data-phase registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_read_q  <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_mask_q  <= 4'b0000;
    end else begin
      dp_read_q  <= dp_read_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      dp_mask_q  <= dp_mask_d;
    end
  end

  // Capture the address phase only when the bus advances
  always_comb begin
    dp_read_d  = dp_read_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    dp_mask_d  = dp_mask_q;
    if (HREADY) begin
      dp_read_d  = rd_ap_s;
      dp_write_d = wr_ap_s;
      dp_addr_d  = HADDR[AW-1:2];
      dp_mask_d  = byte_mask(HSIZE, HADDR[1:0]);
    end else begin
      dp_read_d  = dp_read_q;
      dp_write_d = dp_write_q;
    end
  end

  assign defer_s     = dp_write_q & rd_ap_s;
  assign drain_ack_s = drain_req_s & ~dp_write_q;

  ahb_sram_wbuf #(.WAW(WAW)) u_wbuf (
    .clk_i        (HCLK),
    .rst_ni       (HRESETn),
    .load_i       (defer_s),
    .drain_ack_i  (drain_ack_s),
    .ld_addr_i    (dp_addr_q),
    .ld_mask_i    (dp_mask_q),
    .ld_data_i    (HWDATA),
    .rd_ap_i      (rd_ap_s),
    .dp_addr_i    (dp_addr_q),
    .sram_rdata_i (SRAMRDATA),
    .pend_o       (buf_pend_s),
    .drain_req_o  (drain_req_s),
    .buf_addr_o   (buf_addr_s),
    .buf_mask_o   (buf_mask_s),
    .buf_data_o   (buf_data_s),
    .fwd_rdata_o  (fwd_rdata_s)
  );

  // SRAM port arbitration: read address phase, then direct write, then drain
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = HADDR[AW-1:2];
    SRAMWDATA = buf_data_s;
    if (rd_ap_s) begin
      SRAMCS   = 1'b1;
      SRAMADDR = HADDR[AW-1:2];
    end else if (dp_write_q) begin
      SRAMCS    = 1'b1;
      SRAMADDR  = dp_addr_q;
      SRAMWEN   = dp_mask_q;
      SRAMWDATA = HWDATA;
    end else if (buf_pend_s) begin
      SRAMCS    = 1'b1;
      SRAMADDR  = buf_addr_s;
      SRAMWEN   = buf_mask_s;
      SRAMWDATA = buf_data_s;
    end else begin
      SRAMCS  = 1'b0;
      SRAMWEN = 4'b0000;
    end
  end

  assign HRDATA    = dp_read_q ? fwd_rdata_s : 32'h0000_0000;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed bench for ahb_sram_bridge: behavioural SRAM, reference memory image and a
// read-data scoreboard that is filled at each read address phase.
module tb_ahb_sram_bridge;
  import ahb_sram_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] SRAMRDATA = 32'h0000_0000;
  logic [13:0] SRAMADDR;
  logic [31:0] SRAMWDATA;
  logic [3:0]  SRAMWEN;
  logic        SRAMCS;

  int n_total = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[int];
  logic [31:0] model[int];

  ahb_sram_bridge #(.AW(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] init_word(input int w);
    logic [13:0] a;
    a = w[13:0];
    return {16'hA5C3, 2'b00, a};
  endfunction

  // Synchronous single-port SRAM: read data registered, byte-lane writes
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      logic [31:0] cur;
      cur = mem.exists(int'(SRAMADDR)) ? mem[int'(SRAMADDR)] : init_word(int'(SRAMADDR));
      SRAMRDATA <= cur;
      for (int b = 0; b < 4; b++) begin
        if (SRAMWEN[b]) cur[8*b +: 8] = SRAMWDATA[8*b +: 8];
      end
      mem[int'(SRAMADDR)] = cur;
    end
  end

  function automatic logic [31:0] model_rd(input int w);
    return model.exists(w) ? model[w] : init_word(w);
  endfunction

  task automatic model_wr(input int w, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] cur;
    cur = model_rd(w);
    for (int b = 0; b < 4; b++) begin
      if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
    end
    model[w] = cur;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, HRDATA);
    end else begin
      e = exp_q.pop_front();
      chk(tag, HRDATA, e);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [15:0] a, input logic [31:0] wd);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a; HWDATA = wd; HREADY = 1'b1;
  endtask

  task automatic idle(input logic [31:0] wd);
    drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 16'h0000, wd);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] wd);
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a, wd);
    exp_q.push_back(model_rd(int'(a >> 2)));
  endtask

  task automatic tick();
    chk("no_direct_drain_clash", {31'd0, dut.dp_write_q & dut.buf_pend_s}, 32'd0);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    idle(32'h0000_0000);
    @(negedge HCLK);
    chk("rst_cs", {31'd0, SRAMCS}, 32'd0);
    chk("rst_wen", {28'd0, SRAMWEN}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_readyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'd0, HRESP}, 32'd0);
    chk("rst_pend", {31'd0, dut.buf_pend_s}, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Word read at 0x0010
    rd(16'h0010, 32'h0);
    @(negedge HCLK);
    chk("rd_ap_cs", {31'd0, SRAMCS}, 32'd1);
    chk("rd_ap_addr", {18'd0, SRAMADDR}, 32'h0004);
    chk("rd_ap_wen", {28'd0, SRAMWEN}, 32'd0);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    chk_rd("rd_data_0010");
    chk("rd_readyout", {31'd0, HREADYOUT}, 32'd1);
    tick();

    // Direct word write 0xDEADBEEF to 0x0020
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0020, 32'h0);
    @(negedge HCLK);
    chk("wr_ap_no_cs", {31'd0, SRAMCS}, 32'd0);
    tick();
    idle(32'hDEAD_BEEF);
    model_wr(8, 4'b1111, 32'hDEAD_BEEF);
    @(negedge HCLK);
    chk("dwr_cs", {31'd0, SRAMCS}, 32'd1);
    chk("dwr_wen", {28'd0, SRAMWEN}, 32'hF);
    chk("dwr_addr", {18'd0, SRAMADDR}, 32'h0008);
    chk("dwr_wdata", SRAMWDATA, 32'hDEAD_BEEF);
    chk("dwr_pend", {31'd0, dut.buf_pend_s}, 32'd0);
    tick();
    @(negedge HCLK);
    chk("dwr_after_cs", {31'd0, SRAMCS}, 32'd0);
    tick();

    // Old word 0x11223344, then byte write 0xAB to 0x0023 colliding with a read of 0x0020
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0020, 32'h0);
    tick();
    idle(32'h1122_3344);
    model_wr(8, 4'b1111, 32'h1122_3344);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 16'h0023, 32'h0);
    tick();
    model_wr(8, 4'b1000, 32'hAB00_0000);
    rd(16'h0020, 32'hAB00_0000);
    @(negedge HCLK);
    chk("defer_rd_wins_wen", {28'd0, SRAMWEN}, 32'd0);
    chk("defer_rd_addr", {18'd0, SRAMADDR}, 32'h0008);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    chk_rd("fwd_byte_0020");
    chk("drain_cs", {31'd0, SRAMCS}, 32'd1);
    chk("drain_wen", {28'd0, SRAMWEN}, 32'h8);
    chk("drain_addr", {18'd0, SRAMADDR}, 32'h0008);
    chk("drain_wdata", SRAMWDATA, 32'hAB00_0000);
    tick();
    @(negedge HCLK);
    chk("drain_done_cs", {31'd0, SRAMCS}, 32'd0);
    tick();
    rd(16'h0020, 32'h0);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    chk_rd("sram_merged_0020");
    tick();

    // Halfword write to 0x0042 held across three reads of 0x0100
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 16'h0042, 32'h0);
    tick();
    model_wr(16, 4'b1100, 32'h1234_0000);
    rd(16'h0100, 32'h1234_0000);
    tick();
    for (int k = 0; k < 2; k++) begin
      rd(16'h0100, 32'h0);
      @(negedge HCLK);
      chk_rd("rd_0100_during_pend");
      chk("no_drain_wen", {28'd0, SRAMWEN}, 32'd0);
      chk("pend_held", {31'd0, dut.buf_pend_s}, 32'd1);
      tick();
    end
    idle(32'h0);
    @(negedge HCLK);
    chk_rd("rd_0100_last");
    chk("half_drain_wen", {28'd0, SRAMWEN}, 32'hC);
    chk("half_drain_addr", {18'd0, SRAMADDR}, 32'h0010);
    chk("half_drain_wdata", SRAMWDATA, 32'h1234_0000);
    tick();
    rd(16'h0040, 32'h0);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    chk_rd("sram_half_0040");
    tick();

    // W(A) then R(A) twice: forwarding persists while pend holds
    drive(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 16'h0044, 32'h0);
    tick();
    model_wr(17, 4'b1111, 32'h0F0E_0D0C);
    rd(16'h0044, 32'h0F0E_0D0C);
    tick();
    rd(16'h0044, 32'h0);
    @(negedge HCLK);
    chk_rd("fwd_word_0044_a");
    tick();
    idle(32'h0);
    @(negedge HCLK);
    chk_rd("fwd_word_0044_b");
    tick();

    // HREADY low from another slave: no access, no data phase captured
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'h0);
    HREADY = 1'b0;
    @(negedge HCLK);
    chk("hready_low_cs", {31'd0, SRAMCS}, 32'd0);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0048, 32'h0);
    HREADY = 1'b0;
    tick();
    idle(32'h5555_5555);
    @(negedge HCLK);
    chk("hready_low_no_rdata", HRDATA, 32'd0);
    chk("hready_low_no_write", {31'd0, SRAMCS}, 32'd0);
    tick();

    // Reset while a deferred write is pending
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0060, 32'h0);
    tick();
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0100, 32'h7777_7777);
    tick();
    chk("pre_rst_pend", {31'd0, dut.buf_pend_s}, 32'd1);
    idle(32'h0);
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_cs", {31'd0, SRAMCS}, 32'd0);
    chk("rst_mid_pend", {31'd0, dut.buf_pend_s}, 32'd0);
    chk("rst_mid_hrdata", HRDATA, 32'd0);
    tick();
    HRESETn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      chk("post_rst_no_drain", {31'd0, SRAMCS}, 32'd0);
      tick();
    end

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
